// File: rtl/eprom_pkg.sv
// Shared encodings for the EPROM program controller and the EPROM model.
// The BLANK state exists only when EPROM_PROG_CTRL_BLANK_CHECK_EN is defined.
package eprom_pkg;

    localparam int EPROM_ADDR_W = 4;
    localparam int EPROM_DATA_W = 16;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_PROG  = 2'b01,
        OP_ERASE = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_PROG    = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_ERASE   = 3'd4,
`ifdef EPROM_PROG_CTRL_BLANK_CHECK_EN
        ST_BLANK   = 3'd5,
`endif
        ST_RESP    = 3'd6
    } state_t;

    // Counter width able to hold the longer of the two strobe windows.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/eprom_pulse_timer.sv
// Load/count-down counter that times the EPROM program and erase strobes.
// done is high during the last cycle of the loaded window.
module eprom_pulse_timer
    import eprom_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign done = (count_reg == CNT_W'(1));

endmodule

// File: rtl/eprom_prog_ctrl.sv
// READ / PROGRAM / ERASE sequencer for the 16x16 EPROM with program-verify retries.
// Define EPROM_PROG_CTRL_BLANK_CHECK_EN to add a post-erase blank scan.
module eprom_prog_ctrl
    import eprom_pkg::*;
#(
    parameter int ADDR_W       = EPROM_ADDR_W,
    parameter int DATA_W       = EPROM_DATA_W,
    parameter int PROG_CYCLES  = 2,
    parameter int ERASE_CYCLES = 4,
    parameter int MAX_RETRY    = 3
`ifdef EPROM_PROG_CTRL_BLANK_CHECK_EN
    ,
    parameter logic [DATA_W-1:0] ERASED_VAL = '0
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_erase,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W   = timer_width(PROG_CYCLES, ERASE_CYCLES);
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    state_t             state_reg;
    logic [RETRY_W-1:0] retry_reg;
    logic               accept;
    logic               verify_match;
    logic               retry_ok;
    logic               timer_load;
    logic [CNT_W-1:0]   timer_val;
    logic               timer_done;

`ifdef EPROM_PROG_CTRL_BLANK_CHECK_EN
    logic               scan_done_reg;
    logic               cmp_valid_reg;
    logic [ADDR_W-1:0]  sample_addr_reg;
    logic [DATA_W-1:0]  sample_data_reg;
`endif

    assign accept       = cmd_valid && cmd_ready;
    assign verify_match = (mem_rdata == mem_wdata);
    assign retry_ok     = (retry_reg < RETRY_W'(MAX_RETRY));

    // The timer is loaded on the same edge the FSM raises a strobe.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = CNT_W'(PROG_CYCLES);
        case (state_reg)
            ST_IDLE: begin
                if (accept && cmd_op == OP_PROG) begin
                    timer_load = 1'b1;
                end else if (accept && cmd_op == OP_ERASE) begin
                    timer_load = 1'b1;
                    timer_val  = CNT_W'(ERASE_CYCLES);
                end
            end
            ST_VERIFY: begin
                if (!verify_match && retry_ok) begin
                    timer_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    eprom_pulse_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .load_val(timer_val),
        .done    (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            retry_reg <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_erase <= 1'b0;
            mem_wdata <= '0;
`ifdef EPROM_PROG_CTRL_BLANK_CHECK_EN
            scan_done_reg   <= 1'b0;
            cmp_valid_reg   <= 1'b0;
            sample_addr_reg <= '0;
            sample_data_reg <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        mem_addr  <= cmd_addr;
                        mem_wdata <= cmd_wdata;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        retry_reg <= '0;
                        case (op_t'(cmd_op))
                            OP_READ: state_reg <= ST_RD_WAIT;
                            OP_PROG: begin
                                mem_we    <= 1'b1;
                                state_reg <= ST_PROG;
                            end
                            OP_ERASE: begin
                                mem_erase <= 1'b1;
                                state_reg <= ST_ERASE;
                            end
                            default: begin
                                rsp_err   <= 1'b1;
                                state_reg <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_RD_WAIT: begin
                    rsp_rdata <= mem_rdata;
                    state_reg <= ST_RESP;
                end
                ST_PROG: begin
                    if (timer_done) begin
                        mem_we    <= 1'b0;
                        state_reg <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    rsp_rdata <= mem_rdata;
                    if (verify_match) begin
                        state_reg <= ST_RESP;
                    end else if (retry_ok) begin
                        retry_reg <= retry_reg + RETRY_W'(1);
                        mem_we    <= 1'b1;
                        state_reg <= ST_PROG;
                    end else begin
                        rsp_err   <= 1'b1;
                        state_reg <= ST_RESP;
                    end
                end
                ST_ERASE: begin
                    if (timer_done) begin
                        mem_erase <= 1'b0;
`ifdef EPROM_PROG_CTRL_BLANK_CHECK_EN
                        mem_addr      <= '0;
                        scan_done_reg <= 1'b0;
                        cmp_valid_reg <= 1'b0;
                        state_reg     <= ST_BLANK;
`else
                        state_reg <= ST_RESP;
`endif
                    end
                end
`ifdef EPROM_PROG_CTRL_BLANK_CHECK_EN
                // Each word is sampled while its address is presented and compared
                // one cycle later, hence the trailing compare cycle after the last address.
                ST_BLANK: begin
                    if (cmp_valid_reg && sample_data_reg != ERASED_VAL && !rsp_err) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= DATA_W'(sample_addr_reg);
                    end
                    sample_data_reg <= mem_rdata;
                    sample_addr_reg <= mem_addr;
                    cmp_valid_reg   <= !scan_done_reg;
                    if (scan_done_reg) begin
                        state_reg <= ST_RESP;
                    end else if (mem_addr == {ADDR_W{1'b1}}) begin
                        scan_done_reg <= 1'b1;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
`endif
                // rsp_valid is raised one cycle into RESP, after rsp_rdata has settled.
                ST_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        retry_reg <= '0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eprom_prog_ctrl.sv
// Directed bench for eprom_prog_ctrl with a behavioural 16x16 EPROM model.
// Builds with or without EPROM_PROG_CTRL_BLANK_CHECK_EN.
`timescale 1ns/1ps
module tb_eprom_prog_ctrl;
    import eprom_pkg::*;

`ifdef EPROM_PROG_CTRL_BLANK_CHECK_EN
    localparam int          ERASE_LAT   = 22;
    localparam logic        FAULT_ERR   = 1'b1;
    localparam logic [15:0] FAULT_RDATA = 16'h000A;
`else
    localparam int          ERASE_LAT   = 5;
    localparam logic        FAULT_ERR   = 1'b0;
    localparam logic [15:0] FAULT_RDATA = 16'h0000;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] stuck;
        logic        efault;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        int          exp_pulses;
        int          exp_erase;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [3:0]  mem_addr;
    logic        mem_we;
    logic        mem_erase;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    eprom_prog_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_erase(mem_erase),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // EPROM model: asynchronous read, stuck-at-0 mask on writes, one location that can refuse erase.
    logic [15:0] mem [16];
    logic [15:0] stuck_mask = 16'h0000;
    logic        erase_fault = 1'b0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata & ~stuck_mask;
        if (mem_erase) begin
            for (int i = 0; i < 16; i++) begin
                if (!(erase_fault && i == 10)) mem[i] <= 16'h0000;
            end
        end
    end

    int   we_cycles = 0;
    int   we_pulses = 0;
    int   erase_cycles = 0;
    int   both_high = 0;
    logic we_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_we) we_cycles++;
        if (mem_we && !we_prev) we_pulses++;
        if (mem_erase) erase_cycles++;
        if (mem_we && mem_erase) both_high++;
        we_prev = mem_we;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] wdata,
                                input logic [15:0] stuck, input logic efault, input logic [15:0] rdata,
                                input logic err, input int lat, input int we, input int pulses, input int er);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.stuck = stuck; v.efault = efault;
        v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
        v.exp_we = we; v.exp_pulses = pulses; v.exp_erase = er;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int we0, p0, e0, lat;
        stuck_mask  = v.stuck;
        erase_fault = v.efault;
        @(negedge clk);
        check($sformatf("v%0d cmd_ready idle", idx), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        we0 = we_cycles; p0 = we_pulses; e0 = erase_cycles;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check($sformatf("v%0d busy", idx), busy, 1);
        check($sformatf("v%0d cmd_ready busy", idx), cmd_ready, 0);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check($sformatf("v%0d rsp_valid drop", idx), rsp_valid, 0);
        check($sformatf("v%0d cmd_ready after", idx), cmd_ready, 1);
        check($sformatf("v%0d we cycles", idx), we_cycles - we0, v.exp_we);
        check($sformatf("v%0d we pulses", idx), we_pulses - p0, v.exp_pulses);
        check($sformatf("v%0d erase cycles", idx), erase_cycles - e0, v.exp_erase);
        $display("vec %0d op=%0d addr=%0h wdata=%04h -> rdata=%04h err=%0d lat=%0d",
                 idx, v.op, v.addr, v.wdata, v.exp_rdata, v.exp_err, lat);
    endtask

    vec_t vecs[14];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   we0, lat;
        logic seen_valid;

        vecs[0]  = mk(2'b01, 4'h1, 16'h0034, 16'h0000, 1'b0, 16'h0034, 1'b0, 4, 2, 1, 0);
        vecs[1]  = mk(2'b00, 4'h1, 16'h0000, 16'h0000, 1'b0, 16'h0034, 1'b0, 2, 0, 0, 0);
        vecs[2]  = mk(2'b01, 4'h3, 16'h0055, 16'h0001, 1'b0, 16'h0054, 1'b1, 13, 8, 4, 0);
        vecs[3]  = mk(2'b01, 4'h5, 16'h0055, 16'h0000, 1'b0, 16'h0055, 1'b0, 4, 2, 1, 0);
        vecs[4]  = mk(2'b01, 4'h7, 16'h0039, 16'h0000, 1'b0, 16'h0039, 1'b0, 4, 2, 1, 0);
        vecs[5]  = mk(2'b01, 4'hF, 16'hBEEF, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 4, 2, 1, 0);
        vecs[6]  = mk(2'b00, 4'hF, 16'h0000, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 2, 0, 0, 0);
        vecs[7]  = mk(2'b10, 4'h0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, ERASE_LAT, 0, 0, 4);
        vecs[8]  = mk(2'b00, 4'h5, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 2, 0, 0, 0);
        vecs[9]  = mk(2'b00, 4'h7, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 2, 0, 0, 0);
        vecs[10] = mk(2'b01, 4'hA, 16'h00AA, 16'h0000, 1'b0, 16'h00AA, 1'b0, 4, 2, 1, 0);
        vecs[11] = mk(2'b10, 4'h0, 16'h0000, 16'h0000, 1'b1, FAULT_RDATA, FAULT_ERR, ERASE_LAT, 0, 0, 4);
        vecs[12] = mk(2'b00, 4'hA, 16'h0000, 16'h0000, 1'b0, 16'h00AA, 1'b0, 2, 0, 0, 0);
        vecs[13] = mk(2'b11, 4'h6, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b1, 1, 0, 0, 0);

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 4'h0;
        cmd_wdata = 16'h0000; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset cmd_ready", cmd_ready, 1);
        check("reset busy", busy, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_err", rsp_err, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_erase", mem_erase, 0);
        check("reset mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);
        stuck_mask = 16'h0000;
        erase_fault = 1'b0;

        // Response held for 5 cycles while a second command is offered and must be ignored.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'hA; cmd_wdata = 16'h0000;
        we0 = we_cycles;
        @(posedge clk);
        #1;
        cmd_op = 2'b01; cmd_addr = 4'h2; cmd_wdata = 16'h7777;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold latency", lat, 2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d rsp_valid", c), rsp_valid, 1);
            check($sformatf("hold%0d rsp_rdata", c), rsp_rdata, 16'h00AA);
            check($sformatf("hold%0d rsp_err", c), rsp_err, 0);
            check($sformatf("hold%0d cmd_ready", c), cmd_ready, 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("hold release cmd_ready", cmd_ready, 1);
        check("hold ignored cmd we", we_cycles - we0, 0);
        $display("hold sequence: READ A held 5 cycles, PROGRAM offered while busy");

        // Reset asserted in the middle of a program pulse.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'h2; cmd_wdata = 16'h1234;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("midprog mem_we high", mem_we, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midprog mem_we async drop", mem_we, 0);
        check("midprog busy drop", busy, 0);
        check("midprog cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen_valid = 1'b1;
        end
        check("midprog no response", seen_valid, 0);
        check("midprog idle mem_we", mem_we, 0);
        $display("reset sequence: reset during PROG, no response issued");

        check("we/erase never both high", both_high, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
